// File: rtl/spi_xip_pkg.sv
// rtl/spi_xip_pkg.sv - shared constants, state encoding and helpers for the SPI XIP bridge
package spi_xip_pkg;
  localparam logic [31:0] FLASH_BASE  = 32'h3000_0000;
  localparam logic [31:0] FLASH_END   = 32'h3fff_ffff;
  localparam logic [15:0] SPI_DIV     = 16'h0001;
  localparam logic [7:0]  SPI_SS_MASK = 8'h01;

  localparam logic [31:0] REG_RX0     = 32'h00;
  localparam logic [31:0] REG_TX0     = 32'h00;
  localparam logic [31:0] REG_TX1     = 32'h04;
  localparam logic [31:0] REG_CTRL    = 32'h10;
  localparam logic [31:0] REG_DIVIDER = 32'h14;
  localparam logic [31:0] REG_SS      = 32'h18;

  localparam logic [31:0] CTRL_XIP      = 32'h0000_2540;
  localparam logic [7:0]  FLASH_READ_OP = 8'h03;
  localparam int          CTRL_GO_BSY   = 8;

  typedef enum logic [3:0] {
    IDLE, PASS, ERR, W_TX1, W_DIV, W_SS, W_CTRL, R_POLL, R_RX, RESP
  } state_t;

  function automatic logic in_window(input logic [31:0] addr);
    return (addr >= FLASH_BASE) && (addr <= FLASH_END);
  endfunction

  // First byte shifted in lands in rx[31:24]; upstream expects it in the low byte.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/spi_xip_bridge_if.sv
// rtl/spi_xip_bridge_if.sv - APB bus bundle used for both the upstream and downstream sides
interface spi_xip_bridge_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
                  input  pready, prdata, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
                  output pready, prdata, pslverr);
endinterface

// File: rtl/spi_xip_apb_master.sv
// rtl/spi_xip_apb_master.sv - single-transfer APB master; a start on the done cycle chains the next setup
import spi_xip_pkg::*;

module spi_xip_apb_master (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic                    write,
  input  logic [3:0]              strb,
  input  logic [2:0]              prot,
  output logic                    done,
  output logic [31:0]             rdata,
  output logic                    err,
  spi_xip_bridge_if.master        bus
);
  typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ACCESS} mstate_t;

  mstate_t     state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [3:0]  strb_q;
  logic [2:0]  prot_q;
  logic        accept;

  assign done   = (state == M_ACCESS) && bus.pready;
  assign err    = done && bus.pslverr;
  assign rdata  = bus.prdata;
  assign accept = start && ((state == M_IDLE) || done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= M_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      prot_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        write_q <= write;
        strb_q  <= strb;
        prot_q  <= prot;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      M_IDLE:   if (start) state_nxt = M_SETUP;
      M_SETUP:  state_nxt = M_ACCESS;
      M_ACCESS: if (bus.pready) state_nxt = start ? M_SETUP : M_IDLE;
      default:  state_nxt = M_IDLE;
    endcase
  end

  assign bus.psel    = (state != M_IDLE);
  assign bus.penable = (state == M_ACCESS);
  assign bus.paddr   = addr_q;
  assign bus.pwdata  = wdata_q;
  assign bus.pwrite  = write_q;
  assign bus.pstrb   = strb_q;
  assign bus.pprot   = prot_q;
endmodule

// File: rtl/spi_xip_bridge.sv
// rtl/spi_xip_bridge.sv - APB pass-through bridge running flash-window reads as SPI READ transfers; SPI_XIP_CACHE_EN adds a one-word buffer
import spi_xip_pkg::*;

module spi_xip_bridge (
  input  logic              clk,
  input  logic              rst,
  spi_xip_bridge_if.slave   in_bus,
  spi_xip_bridge_if.master  spi_bus
);
  state_t      state, state_nxt;
  logic [31:0] resp_data, resp_data_nxt;
  logic        resp_err, resp_err_nxt;
  logic        m_start, m_write, m_done, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;
  logic        up_pready, up_pslverr;
  logic [31:0] up_prdata;
  logic        hit;
  logic [31:0] hit_data;

  spi_xip_apb_master u_master (
    .clk(clk), .rst(rst), .start(m_start), .addr(m_addr), .wdata(m_wdata),
    .write(m_write), .strb(m_strb), .prot(m_prot), .done(m_done),
    .rdata(m_rdata), .err(m_err), .bus(spi_bus)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      resp_data <= resp_data_nxt;
      resp_err  <= resp_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    resp_data_nxt = resp_data;
    resp_err_nxt  = resp_err;
    m_start = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_write = 1'b0;
    m_strb  = 4'hf;
    m_prot  = 3'b000;
    up_pready  = 1'b0;
    up_prdata  = '0;
    up_pslverr = 1'b0;
    case (state)
      IDLE: if (in_bus.psel) begin
        if (!in_window(in_bus.paddr)) begin
          state_nxt = PASS;
          m_start = 1'b1;
          m_addr  = in_bus.paddr;
          m_wdata = in_bus.pwdata;
          m_write = in_bus.pwrite;
          m_strb  = in_bus.pstrb;
          m_prot  = in_bus.pprot;
        end else if (in_bus.pwrite) begin
          state_nxt = ERR;
        end else if (hit) begin
          state_nxt     = RESP;
          resp_data_nxt = hit_data;
          resp_err_nxt  = 1'b0;
        end else begin
          state_nxt = W_TX1;
          m_start = 1'b1;
          m_addr  = REG_TX1;
          m_wdata = {FLASH_READ_OP, in_bus.paddr[23:2], 2'b00};
          m_write = 1'b1;
        end
      end
      PASS: if (m_done) begin
        state_nxt     = RESP;
        resp_data_nxt = m_rdata;
        resp_err_nxt  = m_err;
      end
      ERR: if (in_bus.psel && in_bus.penable) begin
        up_pready  = 1'b1;
        up_pslverr = 1'b1;
        state_nxt  = IDLE;
      end
      W_TX1, W_DIV, W_SS, W_CTRL, R_POLL, R_RX: if (m_done) begin
        if (m_err) begin
          state_nxt     = RESP;
          resp_data_nxt = '0;
          resp_err_nxt  = 1'b1;
        end else begin
          m_start = (state != R_RX);
          m_write = (state == W_TX1) || (state == W_DIV) || (state == W_SS);
          case (state)
            W_TX1:  begin state_nxt = W_DIV;  m_addr = REG_DIVIDER; m_wdata = {16'h0, SPI_DIV}; end
            W_DIV:  begin state_nxt = W_SS;   m_addr = REG_SS;      m_wdata = {24'h0, SPI_SS_MASK}; end
            W_SS:   begin state_nxt = W_CTRL; m_addr = REG_CTRL;    m_wdata = CTRL_XIP; end
            W_CTRL: begin state_nxt = R_POLL; m_addr = REG_CTRL; end
            R_POLL: begin
              state_nxt = m_rdata[CTRL_GO_BSY] ? R_POLL : R_RX;
              m_addr    = m_rdata[CTRL_GO_BSY] ? REG_CTRL : REG_RX0;
            end
            default: begin
              state_nxt     = RESP;
              resp_data_nxt = byte_swap(m_rdata);
              resp_err_nxt  = 1'b0;
            end
          endcase
        end
      end
      RESP: if (in_bus.psel && in_bus.penable) begin
        up_pready  = 1'b1;
        up_prdata  = resp_data;
        up_pslverr = resp_err;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_bus.pready  = up_pready;
  assign in_bus.prdata  = up_prdata;
  assign in_bus.pslverr = up_pslverr;

`ifdef SPI_XIP_CACHE_EN
  logic        cache_valid;
  logic [29:0] cache_tag, addr_q;
  logic [31:0] cache_data;
  logic        fill, inval;

  assign hit      = cache_valid && (cache_tag == in_bus.paddr[31:2]);
  assign hit_data = cache_data;
  assign fill     = (state == R_RX) && m_done && !m_err;
  // Pass-through writes may reprogram the controller, so the buffered word is no longer trusted.
  assign inval    = ((state == IDLE) && in_bus.psel && in_bus.pwrite && !in_window(in_bus.paddr)) ||
                    (m_done && m_err && (state inside {W_TX1, W_DIV, W_SS, W_CTRL, R_POLL, R_RX}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
      addr_q      <= '0;
    end else begin
      if ((state == IDLE) && (state_nxt == W_TX1)) addr_q <= in_bus.paddr[31:2];
      if (inval) begin
        cache_valid <= 1'b0;
      end else if (fill) begin
        cache_valid <= 1'b1;
        cache_tag   <= addr_q;
        cache_data  <= resp_data_nxt;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif
endmodule

// File: tb/tb_spi_xip_bridge.sv
// tb/tb_spi_xip_bridge.sv - self-checking bench with SPI controller/flash model and upstream response model
module tb_spi_xip_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xip_bridge_if up();
  spi_xip_bridge_if dn();

  spi_xip_bridge dut (.clk(clk), .rst(rst), .in_bus(up), .spi_bus(dn));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [3:0]  strb;
  } xfer_t;

  // Controller + flash model
  logic [31:0] ctl_regs [0:7];
  logic [7:0]  fmem [0:63];
  logic [31:0] rx_word;
  logic [31:0] err_addr;
  xfer_t       setup_q;
  xfer_t       xlog[$];
  int          busy_cnt = 0;
  int          acc_cnt = 0;
  int          wait_states = 0;

  // Upstream response expectations
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  int          resp_count = 0;

  function automatic logic [31:0] flash_le(input logic [31:0] addr);
    logic [31:0] w = '0;
    for (int i = 3; i >= 0; i--) w = (w << 8) | 32'(fmem[int'(addr & 32'h3c) + i]);
    return w;
  endfunction

  always @(negedge clk) begin
    logic [5:0] a;
    if (rst) begin
      for (int i = 0; i < 8; i++) ctl_regs[i] = '0;
      busy_cnt = 0;
      acc_cnt = 0;
      rx_word = '0;
      dn.pready = 1'b0;
      dn.prdata = '0;
      dn.pslverr = 1'b0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      dn.pready = 1'b0;
      dn.prdata = '0;
      dn.pslverr = 1'b0;
      if (dn.psel && !dn.penable) begin
        setup_q = '{dn.paddr, dn.pwdata, dn.pwrite, dn.pstrb};
        acc_cnt = 0;
      end else if (dn.psel && dn.penable) begin
        if (acc_cnt < wait_states) begin
          acc_cnt++;
        end else begin
          dn.pready = 1'b1;
          check("dn_hold", {dn.paddr ^ setup_q.addr, dn.pwdata ^ setup_q.wdata} == 64'h0
                && dn.pwrite == setup_q.write, 1);
          xlog.push_back('{dn.paddr, dn.pwdata, dn.pwrite, dn.pstrb});
          if (dn.paddr == err_addr) begin
            dn.pslverr = 1'b1;
            err_addr = 32'hffff_ffff;
          end else if (dn.pwrite) begin
            ctl_regs[dn.paddr[4:2]] = dn.pwdata;
            if (dn.paddr[4:0] == 5'h10 && dn.pwdata[8]) begin
              busy_cnt = 64 * 2 * (int'(ctl_regs[5][15:0]) + 1);
              a = ctl_regs[1][5:0];
              rx_word = {fmem[a], fmem[a + 6'd1], fmem[a + 6'd2], fmem[a + 6'd3]};
            end
          end else begin
            case (dn.paddr[4:0])
              5'h00:   dn.prdata = rx_word;
              5'h10:   dn.prdata = {ctl_regs[4][31:9], busy_cnt > 0, ctl_regs[4][7:0]};
              default: dn.prdata = ctl_regs[dn.paddr[4:2]];
            endcase
          end
        end
      end
    end
  end

  // Compare process: every upstream response against the model expectation
  always @(negedge clk) begin
    if (!rst && up.pready) begin
      check("resp_phase", {up.psel, up.penable}, 2'b11);
      check("resp_once", resp_count, 0);
      check("resp_rdata", up.prdata, exp_rdata);
      check("resp_err", up.pslverr, exp_err);
      resp_count++;
    end
  end

  task automatic apb(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [31:0] e_rdata, input logic e_err,
                     output int lat);
    exp_rdata = e_rdata;
    exp_err = e_err;
    resp_count = 0;
    xlog.delete();
    @(posedge clk); #1;
    up.paddr = addr; up.pwrite = write; up.pwdata = wdata; up.pstrb = strb;
    up.pprot = 3'b010; up.psel = 1'b1; up.penable = 1'b0;
    @(posedge clk); #1;
    up.penable = 1'b1;
    lat = 0;
    while (lat < 3000) begin
      @(negedge clk);
      lat++;
      if (up.pready) break;
    end
    @(posedge clk); #1;
    up.psel = 1'b0; up.penable = 1'b0;
    @(negedge clk);
    check("resp_count", resp_count, 1);
  endtask

  task automatic check_pass_log(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic write, input logic [3:0] strb);
    xfer_t x;
    check("pass_nxfers", xlog.size(), 1);
    if (xlog.size() != 1) return;
    x = xlog.pop_front();
    check("pass_addr", x.addr, addr);
    if (write) check("pass_wdata", x.wdata, wdata);
    check("pass_write", x.write, write);
    check("pass_strb", x.strb, strb);
  endtask

  task automatic check_xip_log(input logic [31:0] exp_tx1);
    xfer_t x;
    int polls = 0;
    check("xip_nxfers", xlog.size() >= 6, 1);
    if (xlog.size() < 6) return;
    x = xlog.pop_front(); check("tx1_addr", x.addr, 32'h04); check("tx1_data", x.wdata, exp_tx1);
    check("tx1_wr", {x.write, x.strb}, 5'h1f);
    x = xlog.pop_front(); check("div_xfer", {x.addr[7:0], x.wdata, x.write}, {8'h14, 32'h1, 1'b1});
    x = xlog.pop_front(); check("ss_xfer", {x.addr[7:0], x.wdata, x.write}, {8'h18, 32'h1, 1'b1});
    x = xlog.pop_front(); check("ctrl_xfer", {x.addr[7:0], x.wdata, x.write}, {8'h10, 32'h2540, 1'b1});
    while (xlog.size() > 1) begin
      x = xlog.pop_front();
      polls++;
      check("poll_xfer", {x.addr, x.write}, {32'h10, 1'b0});
    end
    check("poll_count", polls >= 100 && polls <= 140, 1);
    x = xlog.pop_front();
    check("rx_xfer", {x.addr, x.write}, {32'h00, 1'b0});
  endtask

  initial begin
    int lat;
    int n;
    up.paddr = '0; up.psel = 1'b0; up.penable = 1'b0; up.pwrite = 1'b0;
    up.pwdata = '0; up.pstrb = '0; up.pprot = '0;
    err_addr = 32'hffff_ffff;
    for (int i = 0; i < 64; i++) fmem[i] = 8'(i * 37 + 11);
    fmem[4] = 8'hde; fmem[5] = 8'had; fmem[6] = 8'hbe; fmem[7] = 8'hef;

    repeat (3) @(posedge clk);
    #1;
    check("rst_up_flags", {up.pready, up.pslverr}, 0);
    check("rst_up_prdata", up.prdata, 0);
    check("rst_dn_ctl", {dn.psel, dn.penable, dn.pwrite, dn.pstrb}, 0);
    check("rst_dn_addr", dn.paddr, 0);
    check("rst_dn_wdata", dn.pwdata, 0);
    rst = 1'b0;

    // Pass-through with one controller wait state
    wait_states = 1;
    apb(32'h14, 1'b1, 32'h3, 4'hf, 32'h0, 1'b0, lat);
    check("pass_lat", lat, 4);
    check_pass_log(32'h14, 32'h3, 1'b1, 4'hf);
    apb(32'h14, 1'b0, 32'h0, 4'h0, 32'h3, 1'b0, lat);
    check_pass_log(32'h14, 32'h0, 1'b0, 4'h0);
    apb(32'h00, 1'b1, 32'ha5a5_0000, 4'h3, 32'h0, 1'b0, lat);
    check_pass_log(32'h00, 32'ha5a5_0000, 1'b1, 4'h3);
    apb(32'h2fff_fffc, 1'b1, 32'h1234_5678, 4'hf, 32'h0, 1'b0, lat);
    check_pass_log(32'h2fff_fffc, 32'h1234_5678, 1'b1, 4'hf);
    apb(32'h4000_001c, 1'b0, 32'h0, 4'hf, 32'h1234_5678, 1'b0, lat);
    check_pass_log(32'h4000_001c, 32'h0, 1'b0, 4'hf);
    err_addr = 32'h18;
    apb(32'h18, 1'b0, 32'h0, 4'hf, 32'h0, 1'b1, lat);
    check_pass_log(32'h18, 32'h0, 1'b0, 4'hf);

    // XIP reads
    wait_states = 0;
    apb(32'h3000_0004, 1'b0, 32'h0, 4'hf, 32'hefbe_adde, 1'b0, lat);
    check("xip_lat", lat >= 256, 1);
    check_xip_log(32'h0300_0004);
    apb(32'h3000_0006, 1'b0, 32'h0, 4'hf, flash_le(32'h3000_0004), 1'b0, lat);
`ifdef SPI_XIP_CACHE_EN
    check("hit_nxfers", xlog.size(), 0);
    check("hit_lat", lat, 1);
`else
    check_xip_log(32'h0300_0004);
`endif
    apb(32'h3fff_fffc, 1'b0, 32'h0, 4'hf, flash_le(32'h3fff_fffc), 1'b0, lat);
    check_xip_log(32'h0300_0000 + (32'h3fff_fffc & 32'h00ff_fffc));

    // Flash-window write is rejected without downstream traffic
    apb(32'h3000_0000, 1'b1, 32'hdead_beef, 4'hf, 32'h0, 1'b1, lat);
    check("err_lat", lat, 1);
    check("err_nxfers", xlog.size(), 0);

    // Controller error during W_SS aborts the sequence
    err_addr = 32'h18;
    apb(32'h3000_0010, 1'b0, 32'h0, 4'hf, 32'h0, 1'b1, lat);
    check("abort_nxfers", xlog.size(), 3);
    if (xlog.size() == 3) check("abort_last", xlog[2].addr, 32'h18);
    apb(32'h14, 1'b0, 32'h0, 4'hf, 32'h1, 1'b0, lat);
    check_pass_log(32'h14, 32'h0, 1'b0, 4'hf);

    // Asynchronous reset while polling
    resp_count = 0;
    @(posedge clk); #1;
    up.paddr = 32'h3000_0000; up.pwrite = 1'b0; up.psel = 1'b1; up.penable = 1'b0;
    @(posedge clk); #1;
    up.penable = 1'b1;
    n = 0;
    while (!(dn.psel && dn.paddr == 32'h10 && !dn.pwrite) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("poll_reached", n < 2000, 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_up", {up.pready, up.pslverr}, 0);
    check("arst_prdata", up.prdata, 0);
    check("arst_dn", {dn.psel, dn.penable, dn.pwrite, dn.pstrb}, 0);
    check("arst_dn_addr", dn.paddr, 0);
    up.psel = 1'b0; up.penable = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("arst_no_resp", resp_count, 0);
    apb(32'h3000_0000, 1'b0, 32'h0, 4'hf, flash_le(32'h3000_0000), 1'b0, lat);
    check_xip_log(32'h0300_0000);

    // Repeat read, then a pass-through write forces a fresh sequence
    apb(32'h3000_0008, 1'b0, 32'h0, 4'hf, flash_le(32'h3000_0008), 1'b0, lat);
    check_xip_log(32'h0300_0008);
    apb(32'h3000_0008, 1'b0, 32'h0, 4'hf, flash_le(32'h3000_0008), 1'b0, lat);
`ifdef SPI_XIP_CACHE_EN
    check("hit2_nxfers", xlog.size(), 0);
`else
    check_xip_log(32'h0300_0008);
`endif
    apb(32'h14, 1'b1, 32'h1, 4'hf, 32'h0, 1'b0, lat);
    check_pass_log(32'h14, 32'h1, 1'b1, 4'hf);
    apb(32'h3000_0008, 1'b0, 32'h0, 4'hf, flash_le(32'h3000_0008), 1'b0, lat);
    check_xip_log(32'h0300_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
